tt_sweep_cmp: RTL

Sequential truth-table sweeper that exhaustively compares two N_IN-input, N_OUT-output combinational functions, typically an original boolean expression and its hand-simplified form. It drives every input vector 0 .. 2^N_IN−1 onto a shared bus, compares both function outputs each cycle, and reports equivalence, mismatch count, first failing vector and failing output bits. It sits beside the combinational exercise blocks as their self-checking harness in synthesised designs.

---
 rtl/tt_sweep_cmp_if.sv | 31 +++
 rtl/tt_sweep_cmp.sv | 104 ++++++++++
 2 files changed

// File: rtl/tt_sweep_cmp_if.sv
// Sweep bus between tt_sweep_cmp and the two functions under comparison.
// master: control and function outputs in; slave: the sweeper itself.
interface tt_sweep_cmp_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic             start;
  logic             stop_first;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] y_a;
  logic [N_OUT-1:0] y_b;
  logic             busy;
  logic             done;
  logic             valid;
  logic             equal;
  logic [N_IN:0]    err_cnt;
  logic [N_IN-1:0]  first_vec;
  logic [N_OUT-1:0] err_mask;

  modport master (
    output start, stop_first, y_a, y_b,
    input  vec, busy, done, valid, equal,
    input  err_cnt, first_vec, err_mask
  );

  modport slave (
    input  start, stop_first, y_a, y_b,
    output vec, busy, done, valid, equal,
    output err_cnt, first_vec, err_mask
  );
endinterface

// File: rtl/tt_sweep_cmp.sv
// Exhaustive truth-table sweeper comparing two combinational functions.
// Ports: clk, rst_n (async low), bus (slave: start/stop_first/y_a/y_b in,
// vec/busy/done/valid/equal/err_cnt/first_vec/err_mask out).
module tt_sweep_cmp #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_sweep_cmp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state, nxt;

  logic [N_IN-1:0]  vec_q;
  logic [N_IN:0]    cnt_q;
  logic [N_IN-1:0]  first_q;
  logic [N_OUT-1:0] mask_q;
  logic             valid_q;
  logic             equal_q;
  logic             stop_q;

  logic [N_OUT-1:0] d;
  logic             mis;
  logic             last;
  logic             leave;

  assign d     = bus.y_a ^ bus.y_b;
  assign mis   = |d;
  assign last  = (vec_q == {N_IN{1'b1}});
  // Sweep ends on the last vector or, in stop-first mode, on a miss.
  assign leave = last | (stop_q & mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = SWEEP;
      SWEEP:   if (leave) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      equal_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            stop_q  <= bus.stop_first;
            cnt_q   <= '0;
            first_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            equal_q <= 1'b0;
            vec_q   <= '0;
          end
        end
        SWEEP: begin
          if (mis) begin
            cnt_q  <= cnt_q + (N_IN+1)'(1);
            mask_q <= mask_q | d;
            if (cnt_q == '0) first_q <= vec_q;
          end
          if (!leave) vec_q <= vec_q + N_IN'(1);
        end
        DONE: begin
          valid_q <= 1'b1;
          equal_q <= (cnt_q == '0);
          vec_q   <= '0;
        end
        default: vec_q <= '0;
      endcase
    end
  end

  assign bus.vec       = vec_q;
  assign bus.busy      = (state == SWEEP);
  assign bus.done      = (state == DONE);
  assign bus.valid     = valid_q;
  assign bus.equal     = equal_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.first_vec = first_q;
  assign bus.err_mask  = mask_q;

endmodule
